// File: rtl/decim_sequencer_if.sv
// decim_sequencer_if: valid/ready output stream carrying captured filter words
//   out_data  [DW-1:0]  captured word (master -> slave)
//   out_valid           out_data holds an unconsumed word (master -> slave)
//   out_ready           consumer accepts when out_valid && out_ready (slave -> master)
interface decim_sequencer_if #(
    parameter int DW = 12
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/decim_sequencer.sv
// decim_sequencer: run-control and output scheduler for the ADC decimation path
//   clk           system clock, all logic on posedge
//   rst_n         synchronous active-low reset
//   en            run enable, level-sensitive
//   cfg_osr_log2  window length = 2^cfg_osr_log2, clamped, sampled at start only
//   data_in       filter output word, captured at each RUN window end
//   out_if        valid/ready output stream (master modport)
//   win_end       strobe on the last cycle of each window
//   busy          sequencer not idle
//   overrun       sticky flag: a window-end word was dropped
//   ovr_clr       clears overrun (a simultaneous set wins)
// Optional feature: define DECIM_SETTLE_EN to discard the first SETTLE_WINDOWS
// window ends after every start.
module decim_sequencer #(
    parameter int DW             = 12,
    parameter int OSR_MIN_LOG2   = 4,
    parameter int OSR_MAX_LOG2   = 9,
    parameter int SETTLE_WINDOWS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [3:0]           cfg_osr_log2,
    input  logic [DW-1:0]        data_in,
    input  logic                 ovr_clr,
    decim_sequencer_if.master    out_if,
    output logic                 win_end,
    output logic                 busy,
    output logic                 overrun
);
    localparam int CW = OSR_MAX_LOG2;
    localparam logic [3:0] OSR_MIN = 4'(OSR_MIN_LOG2);
    localparam logic [3:0] OSR_MAX = 4'(OSR_MAX_LOG2);
    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    osr_q, osr_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic [CW-1:0] win_mask;
    logic [3:0]    osr_clamped;
`ifdef DECIM_SETTLE_EN
    localparam int SW = $clog2(SETTLE_WINDOWS + 1);
    logic [SW-1:0] settle_q, settle_d;
`endif
    assign osr_clamped = cfg_osr_log2 < OSR_MIN ? OSR_MIN :
                         cfg_osr_log2 > OSR_MAX ? OSR_MAX : cfg_osr_log2;
    // Low osr_q bits set: the terminal count of the active window.
    assign win_mask = ~({CW{1'b1}} << osr_q);
    assign busy     = state_q != IDLE;
    assign win_end  = busy && cnt_q == win_mask;
    assign overrun  = ovr_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        osr_d   = osr_q;
        data_d  = data_q;
        valid_d = valid_q && !out_if.out_ready;
        ovr_d   = ovr_q && !ovr_clr;
`ifdef DECIM_SETTLE_EN
        settle_d = settle_q;
`endif
        if (state_q == IDLE) begin
            if (en) begin
                osr_d = osr_clamped;
                cnt_d = '0;
`ifdef DECIM_SETTLE_EN
                settle_d = '0;
                state_d  = SETTLE;
`else
                state_d  = RUN;
`endif
            end
        end else if (!en) begin
            // Partial window is abandonned; a pending word stays consumable.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = win_end ? '0 : cnt_q + 1'b1;
            if (win_end && state_q == RUN) begin
                // A handshake in the same cycle frees the slot for the new word.
                if (valid_q && !out_if.out_ready) begin
                    ovr_d = 1'b1;
                end else begin
                    data_d  = data_in;
                    valid_d = 1'b1;
                end
            end
`ifdef DECIM_SETTLE_EN
            if (win_end && state_q == SETTLE) begin
                settle_d = settle_q + 1'b1;
                state_d  = settle_q == SW'(SETTLE_WINDOWS - 1) ? RUN : SETTLE;
            end
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            osr_q   <= OSR_MAX;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef DECIM_SETTLE_EN
            settle_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            osr_q   <= osr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef DECIM_SETTLE_EN
            settle_q <= settle_d;
`endif
        end
    end
endmodule

// File: tb/tb_decim_sequencer.sv
// tb_decim_sequencer: directed self-checking bench for decim_sequencer
module tb_decim_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  cfg_osr_log2 = 4'd4;
    logic [11:0] data_in = '0;
    logic        ovr_clr = 1'b0;
    logic        win_end, busy, overrun;
    int          checks = 0;
    int          errors = 0;
    int          n;

    decim_sequencer_if #(.DW(12)) out_if ();

    decim_sequencer dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_osr_log2(cfg_osr_log2),
        .data_in(data_in), .ovr_clr(ovr_clr), .out_if(out_if),
        .win_end(win_end), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] osr);
        cfg_osr_log2 = osr;
        en = 1'b1;
        tick();
    endtask

    task automatic stop();
        en = 1'b0;
        tick();
        tick();
    endtask

    // Edges advanced until win_end is seen; from a zero count the window length is n+1.
    task automatic wait_win(output int cnt);
        cnt = 0;
        while (!win_end && cnt < 1000) begin
            tick();
            cnt++;
        end
        checks++;
        if (!win_end) begin
            errors++;
            $display("FAIL wait_win timeout got no win_end after %0d cycles", cnt);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (out_if.out_data !== 12'h000) begin errors++; $display("FAIL reset_data got %h exp 000", out_if.out_data); end
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_if.out_valid); end
        checks++; if (win_end !== 1'b0) begin errors++; $display("FAIL reset_win_end got %b exp 0", win_end); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_if.out_ready = 1'b1;
        data_in = 12'h123;
        start(4'd4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
        wait_win(n);
        checks++; if (n + 1 != 16) begin errors++; $display("FAIL basic_len got %0d exp 16", n + 1); end
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_valid got %b exp 0", out_if.out_valid); end
        tick();
        checks++; if (out_if.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_if.out_valid); end
        checks++; if (out_if.out_data !== 12'h123) begin errors++; $display("FAIL basic_data got %h exp 123", out_if.out_data); end
        checks++; if (win_end !== 1'b0) begin errors++; $display("FAIL basic_strobe got %b exp 0", win_end); end
        tick();
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed got %b exp 0", out_if.out_valid); end
        stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", busy); end
    endtask

    task automatic test_clamp();
        out_if.out_ready = 1'b1;
        start(4'd2);
        cfg_osr_log2 = 4'd9;
        wait_win(n);
        checks++; if (n + 1 != 16) begin errors++; $display("FAIL clamp_low got %0d exp 16", n + 1); end
        tick();
        wait_win(n);
        checks++; if (n + 1 != 16) begin errors++; $display("FAIL cfg_ignored got %0d exp 16", n + 1); end
        stop();
        start(4'd12);
        wait_win(n);
        checks++; if (n + 1 != 512) begin errors++; $display("FAIL clamp_high got %0d exp 512", n + 1); end
        stop();
        start(4'd5);
        wait_win(n);
        checks++; if (n + 1 != 32) begin errors++; $display("FAIL osr5_len got %0d exp 32", n + 1); end
        stop();
    endtask

    task automatic test_overrun();
        out_if.out_ready = 1'b0;
        data_in = 12'hA5A;
        start(4'd4);
        wait_win(n);
        tick();
        checks++; if (out_if.out_data !== 12'hA5A) begin errors++; $display("FAIL ovr_first got %h exp a5a", out_if.out_data); end
        data_in = 12'h5A5;
        wait_win(n);
        tick();
        checks++; if (out_if.out_data !== 12'hA5A) begin errors++; $display("FAIL ovr_kept got %h exp a5a", out_if.out_data); end
        checks++; if (out_if.out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", out_if.out_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
        wait_win(n);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b exp 1", overrun); end
        out_if.out_ready = 1'b1;
        tick();
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b exp 0", out_if.out_valid); end
        stop();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_if.out_ready = 1'b0;
        data_in = 12'h111;
        start(4'd4);
        wait_win(n);
        tick();
        checks++; if (out_if.out_data !== 12'h111) begin errors++; $display("FAIL b2b_first got %h exp 111", out_if.out_data); end
        data_in = 12'h222;
        wait_win(n);
        out_if.out_ready = 1'b1;
        tick();
        checks++; if (out_if.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", out_if.out_valid); end
        checks++; if (out_if.out_data !== 12'h222) begin errors++; $display("FAIL b2b_data got %h exp 222", out_if.out_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
        tick();
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_consumed got %b exp 0", out_if.out_valid); end
        stop();
    endtask

    task automatic test_abort();
        out_if.out_ready = 1'b1;
        data_in = 12'h333;
        start(4'd4);
        repeat (7) tick();
        en = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        repeat (20) tick();
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL abort_noload got %b exp 0", out_if.out_valid); end
        checks++; if (out_if.out_data === 12'h333) begin errors++; $display("FAIL abort_data got %h exp not 333", out_if.out_data); end
        start(4'd4);
        wait_win(n);
        checks++; if (n + 1 != 16) begin errors++; $display("FAIL abort_restart got %0d exp 16", n + 1); end
        stop();
        out_if.out_ready = 1'b0;
        data_in = 12'h444;
        start(4'd4);
        wait_win(n);
        tick();
        en = 1'b0;
        tick();
        checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 12'h444) begin errors++; $display("FAIL idle_pending got %b/%h exp 1/444", out_if.out_valid, out_if.out_data); end
        out_if.out_ready = 1'b1;
        tick();
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL idle_consume got %b exp 0", out_if.out_valid); end
    endtask

    task automatic test_reset_mid();
        out_if.out_ready = 1'b0;
        data_in = 12'h555;
        start(4'd4);
        wait_win(n);
        tick();
        wait_win(n);
        tick();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL mid_pre_overrun got %b exp 1", overrun); end
        rst_n = 1'b0;
        en = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || out_if.out_valid !== 1'b0 || overrun !== 1'b0 || out_if.out_data !== 12'h000) begin
            errors++; $display("FAIL mid_reset got busy=%b valid=%b ovr=%b data=%h exp 0/0/0/000", busy, out_if.out_valid, overrun, out_if.out_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_settle();
        int tot;
        out_if.out_ready = 1'b1;
        data_in = 12'h456;
        start(4'd4);
        wait_win(n);
        tot = n + 1;
        tick();
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL settle_w1 got %b exp 0", out_if.out_valid); end
        wait_win(n);
        tot += n + 1;
        tick();
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL settle_w2 got %b exp 0", out_if.out_valid); end
        wait_win(n);
        tot += n + 1;
        tick();
        checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 12'h456) begin errors++; $display("FAIL settle_w3 got %b/%h exp 1/456", out_if.out_valid, out_if.out_data); end
        checks++; if (tot != 48) begin errors++; $display("FAIL settle_cycles got %0d exp 48", tot); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL settle_overrun got %b exp 0", overrun); end
        stop();
    endtask

    initial begin
        out_if.out_ready = 1'b0;
        test_reset();
`ifdef DECIM_SETTLE_EN
        test_settle();
`else
        test_basic();
        test_clamp();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
